// File: rtl/axis_switch_pkg.sv
// Shared definitions for the buffered N-to-1 AXI-Stream switch.
// Holds the arbiter state type, arbitration mode encodings and the helper
// that sizes the source-ID field (at least one bit, even for two ports).
package axis_switch_pkg;

  typedef enum logic [0:0] {
    ArbIdle,
    ArbGrant
  } arb_state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  function automatic int unsigned id_w(input int unsigned n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_switch_nto1_buffered_if.sv
// Bus bundle for axis_switch_nto1_buffered.
// Carries the packed per-port ingress streams, the single egress stream with
// its source ID, and the per-port FIFO occupancy.
// Modports:
//   slave  - the switch: consumes s_axis_*, produces m_axis_* and fifo_level
//   master - the environment: produces s_axis_*, consumes m_axis_*
interface axis_switch_nto1_buffered_if
  import axis_switch_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned TDATA_L    = 512,
  parameter int unsigned TUSER_L    = 81,
  parameter int unsigned TKEEP_L    = 64,
  parameter int unsigned FIFO_DEPTH = 16
) ();

  localparam int unsigned ID_W  = id_w(NUM_PORTS);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_PORTS*TDATA_L-1:0] s_axis_tdata;
  logic [NUM_PORTS*TKEEP_L-1:0] s_axis_tkeep;
  logic [NUM_PORTS*TUSER_L-1:0] s_axis_tuser;
  logic [NUM_PORTS-1:0]         s_axis_tlast;
  logic [NUM_PORTS-1:0]         s_axis_tvalid;
  logic [NUM_PORTS-1:0]         s_axis_tready;

  logic [TDATA_L-1:0]           m_axis_tdata;
  logic [TKEEP_L-1:0]           m_axis_tkeep;
  logic [TUSER_L-1:0]           m_axis_tuser;
  logic                         m_axis_tlast;
  logic                         m_axis_tvalid;
  logic                         m_axis_tready;
  logic [ID_W-1:0]              m_axis_tid;

  logic [NUM_PORTS*LVL_W-1:0]   fifo_level;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tid, fifo_level
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tid, fifo_level
  );

endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (empties the FIFO)
//   wr_en_i/wr_data_i write strobe and word (ignored while full)
//   rd_en_i           pop the head word (ignored while empty)
//   rd_data_o         current head word, valid whenever !empty_o
//   full_o, empty_o   occupancy flags derived from the registered level
//   level_o           words currently stored (0..DEPTH)
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO refuses a write even when a read happens in the same cycle.
  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok) begin
      level_d = level_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axis_switch_nto1_buffered.sv
// Buffered N-to-1 AXI-Stream packet switch.
// Every ingress port owns a FIFO; a packet-level arbiter (round-robin or
// fixed priority, port 0 highest) grants one port at a time and forwards its
// beats cut-through until the egress handshake of a tlast beat.
// Ports:
//   s_axis_aclk    sole clock (rising edge)
//   s_axis_areset  synchronous active-high reset
//   axis_bus       slave modport: s_axis_* ingress, m_axis_* egress with
//                  source ID m_axis_tid, and per-port fifo_level
module axis_switch_nto1_buffered
  import axis_switch_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned TDATA_L    = 512,
  parameter int unsigned TUSER_L    = 81,
  parameter int unsigned TKEEP_L    = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ARB_MODE   = ARB_RR
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_areset,
  axis_switch_nto1_buffered_if.slave   axis_bus
);

  localparam int unsigned ID_W   = id_w(NUM_PORTS);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FIFO_W = TDATA_L + TKEEP_L + TUSER_L + 1;

  logic [FIFO_W-1:0]    rd_data [NUM_PORTS];
  logic [LVL_W-1:0]     level   [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full, fifo_empty, wr_en, rd_en, s_ready;

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic                 rdy_q;

  logic [FIFO_W-1:0]    head;
  logic                 gnt_empty;
  logic                 m_valid;
  logic                 m_hs;
  logic [ID_W-1:0]      pick;
  logic                 found;
  int                   idx;

  // Ingress is held off for the whole reset cycle and released one edge later.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) rdy_q <= 1'b0;
    else               rdy_q <= 1'b1;
  end

  assign axis_bus.s_axis_tready = s_ready;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign s_ready[i] = rdy_q & ~fifo_full[i];
    assign wr_en[i]   = axis_bus.s_axis_tvalid[i] & s_ready[i];
    assign rd_en[i]   = (state_q == ArbGrant) && (grant_q == ID_W'(i)) &&
                        axis_bus.m_axis_tready;

    // Word layout {tdata, tkeep, tuser, tlast}.
    axis_sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i     (s_axis_aclk),
      .rst_i     (s_axis_areset),
      .wr_en_i   (wr_en[i]),
      .wr_data_i ({axis_bus.s_axis_tdata[i*TDATA_L +: TDATA_L],
                   axis_bus.s_axis_tkeep[i*TKEEP_L +: TKEEP_L],
                   axis_bus.s_axis_tuser[i*TUSER_L +: TUSER_L],
                   axis_bus.s_axis_tlast[i]}),
      .rd_en_i   (rd_en[i]),
      .rd_data_o (rd_data[i]),
      .full_o    (fifo_full[i]),
      .empty_o   (fifo_empty[i]),
      .level_o   (level[i])
    );

    assign axis_bus.fifo_level[i*LVL_W +: LVL_W] = level[i];
  end

  // Head of the granted FIFO drives the egress bus.
  always_comb begin
    head      = '0;
    gnt_empty = 1'b1;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (grant_q == ID_W'(i)) begin
        head      = rd_data[i];
        gnt_empty = fifo_empty[i];
      end
    end
  end

  assign m_valid = (state_q == ArbGrant) && !gnt_empty;
  assign m_hs    = m_valid && axis_bus.m_axis_tready;

  assign axis_bus.m_axis_tvalid = m_valid;
  assign axis_bus.m_axis_tlast  = head[0];
  assign axis_bus.m_axis_tuser  = head[1 +: TUSER_L];
  assign axis_bus.m_axis_tkeep  = head[1+TUSER_L +: TKEEP_L];
  assign axis_bus.m_axis_tdata  = head[1+TUSER_L+TKEEP_L +: TDATA_L];
  assign axis_bus.m_axis_tid    = grant_q;

  // Candidate port for the next packet.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    if (ARB_MODE == ARB_FIXED) begin
      // Descending scan so the lowest non-empty index wins.
      for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
        if (!fifo_empty[i]) pick = ID_W'(i);
      end
    end else begin
      for (int k = 1; k <= int'(NUM_PORTS); k++) begin
        idx = (int'(last_q) + k) % int'(NUM_PORTS);
        if (!found && !fifo_empty[idx]) begin
          pick  = ID_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ArbIdle: begin
        if (!(&fifo_empty)) begin
          state_d = ArbGrant;
          grant_d = pick;
          last_d  = pick;
        end
      end
      ArbGrant: begin
        // Underruns keep the grant; only the tlast handshake releases it.
        if (m_hs && head[0]) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q <= ArbIdle;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_axis_switch_nto1_buffered.sv
// Directed bench for axis_switch_nto1_buffered: two instances (round-robin
// and fixed priority) receive identical stimulus; each scenario task checks
// hand-computed expectations inline.
module tb_axis_switch_nto1_buffered;
  import axis_switch_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam int unsigned UW = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW = 5;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic [NP*DW-1:0] s_tdata = '0;
  logic [NP*KW-1:0] s_tkeep = '0;
  logic [NP*UW-1:0] s_tuser = '0;
  logic [NP-1:0]    s_tlast = '0;
  logic [NP-1:0]    s_tvalid = '0;
  logic             m_tready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          cap_tid[$];
  logic [31:0] cap_data[$];
  logic        cap_last[$];
  logic [7:0]  cap_user[$];
  int          cap_cyc[$];
  int          fx_tid[$];
  logic [31:0] fx_data[$];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_switch_nto1_buffered_if #(.NUM_PORTS(NP), .TDATA_L(DW), .TUSER_L(UW), .TKEEP_L(KW),
    .FIFO_DEPTH(DEPTH)) bus_rr ();
  axis_switch_nto1_buffered_if #(.NUM_PORTS(NP), .TDATA_L(DW), .TUSER_L(UW), .TKEEP_L(KW),
    .FIFO_DEPTH(DEPTH)) bus_fx ();

  assign bus_rr.s_axis_tdata  = s_tdata;
  assign bus_rr.s_axis_tkeep  = s_tkeep;
  assign bus_rr.s_axis_tuser  = s_tuser;
  assign bus_rr.s_axis_tlast  = s_tlast;
  assign bus_rr.s_axis_tvalid = s_tvalid;
  assign bus_rr.m_axis_tready = m_tready;
  assign bus_fx.s_axis_tdata  = s_tdata;
  assign bus_fx.s_axis_tkeep  = s_tkeep;
  assign bus_fx.s_axis_tuser  = s_tuser;
  assign bus_fx.s_axis_tlast  = s_tlast;
  assign bus_fx.s_axis_tvalid = s_tvalid;
  assign bus_fx.m_axis_tready = m_tready;

  axis_switch_nto1_buffered #(.NUM_PORTS(NP), .TDATA_L(DW), .TUSER_L(UW), .TKEEP_L(KW),
    .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_RR)) dut_rr (
    .s_axis_aclk   (clk),
    .s_axis_areset (areset),
    .axis_bus      (bus_rr)
  );

  axis_switch_nto1_buffered #(.NUM_PORTS(NP), .TDATA_L(DW), .TUSER_L(UW), .TKEEP_L(KW),
    .FIFO_DEPTH(DEPTH), .ARB_MODE(ARB_FIXED)) dut_fx (
    .s_axis_aclk   (clk),
    .s_axis_areset (areset),
    .axis_bus      (bus_fx)
  );

  // Egress monitors: inputs only change just after posedge, so a negedge
  // sample of valid && ready predicts the handshake at the next edge.
  always @(negedge clk) begin
    if (!areset && bus_rr.m_axis_tvalid && m_tready) begin
      cap_tid.push_back(int'(bus_rr.m_axis_tid));
      cap_data.push_back(bus_rr.m_axis_tdata);
      cap_last.push_back(bus_rr.m_axis_tlast);
      cap_user.push_back(bus_rr.m_axis_tuser);
      cap_cyc.push_back(cyc);
    end
    if (!areset && bus_fx.m_axis_tvalid && m_tready) begin
      fx_tid.push_back(int'(bus_fx.m_axis_tid));
      fx_data.push_back(bus_fx.m_axis_tdata);
    end
  end

  function automatic logic [7:0] user_of(input logic [31:0] d);
    return d[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] mk(input int p, input int pkt, input int beat);
    return 32'hC000_0000 | (32'(p) << 8) | (32'(pkt) << 4) | 32'(beat);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int p, input logic [31:0] d, input logic last);
    s_tdata[p*DW +: DW] = d;
    s_tkeep[p*KW +: KW] = 4'hF;
    s_tuser[p*UW +: UW] = user_of(d);
    s_tlast[p]  = last;
    s_tvalid[p] = 1'b1;
  endtask

  task automatic clear_caps();
    cap_tid.delete(); cap_data.delete(); cap_last.delete(); cap_user.delete();
    cap_cyc.delete(); fx_tid.delete(); fx_data.delete();
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    tick();
    tick();
    areset = 1'b0;
    tick();
    clear_caps();
  endtask

  task automatic wait_beats(input int n, input bit use_fx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if ((use_fx ? fx_tid.size() : cap_tid.size()) >= n) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic load_two_ports();
    for (int j = 0; j < 6; j++) begin
      set_beat(0, mk(0, j / 2, j % 2), (j % 2) == 1);
      set_beat(1, mk(1, j / 2, j % 2), (j % 2) == 1);
      tick();
    end
    s_tvalid = '0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    m_tready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_rr.m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tvalid: got %b want 0", bus_rr.m_axis_tvalid);
    end
    n_tests++;
    if (bus_rr.s_axis_tready !== 2'b00) begin
      n_fail++; $display("FAIL reset_tready: got %b want 00", bus_rr.s_axis_tready);
    end
    n_tests++;
    if (bus_rr.m_axis_tid !== 1'b0) begin
      n_fail++; $display("FAIL reset_tid: got %0d want 0", bus_rr.m_axis_tid);
    end
    n_tests++;
    if (bus_rr.fifo_level !== '0) begin
      n_fail++; $display("FAIL reset_level: got %0h want 0", bus_rr.fifo_level);
    end
    tick();
    areset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus_rr.s_axis_tready !== 2'b00) begin
      n_fail++; $display("FAIL reset_tready_held: got %b want 00", bus_rr.s_axis_tready);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_rr.s_axis_tready !== 2'b11) begin
      n_fail++; $display("FAIL reset_tready_release: got %b want 11", bus_rr.s_axis_tready);
    end
    tick();
    clear_caps();
  endtask

  task automatic test_single_beat();
    apply_reset();
    m_tready = 1'b1;
    set_beat(0, 32'hA0A0_0000, 1'b1);
    tick();
    s_tvalid = '0;
    @(negedge clk);
    n_tests++;
    if (bus_rr.m_axis_tvalid !== 1'b0 || bus_rr.fifo_level[LW-1:0] !== 5'd1) begin
      n_fail++; $display("FAIL single_cycle1: tvalid %b level %0d want 0 and 1",
                         bus_rr.m_axis_tvalid, bus_rr.fifo_level[LW-1:0]);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_rr.m_axis_tvalid !== 1'b1 || bus_rr.m_axis_tid !== 1'b0 ||
        bus_rr.m_axis_tlast !== 1'b1) begin
      n_fail++; $display("FAIL single_cycle2: tvalid %b tid %0d tlast %b want 1 0 1",
                         bus_rr.m_axis_tvalid, bus_rr.m_axis_tid, bus_rr.m_axis_tlast);
    end
    n_tests++;
    if (bus_rr.m_axis_tdata !== 32'hA0A0_0000 || bus_rr.m_axis_tkeep !== 4'hF ||
        bus_rr.m_axis_tuser !== user_of(32'hA0A0_0000)) begin
      n_fail++; $display("FAIL single_payload: data %h keep %h user %h want a0a00000 f %h",
                         bus_rr.m_axis_tdata, bus_rr.m_axis_tkeep, bus_rr.m_axis_tuser,
                         user_of(32'hA0A0_0000));
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_rr.m_axis_tvalid !== 1'b0 || bus_rr.fifo_level !== '0 || cap_tid.size() != 1) begin
      n_fail++; $display("FAIL single_after: tvalid %b level %0h beats %0d want 0 0 1",
                         bus_rr.m_axis_tvalid, bus_rr.fifo_level, cap_tid.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int etid;
    apply_reset();
    m_tready = 1'b0;
    load_two_ports();
    @(negedge clk);
    n_tests++;
    if (bus_rr.fifo_level !== {5'd6, 5'd6}) begin
      n_fail++; $display("FAIL rr_loaded_level: got %0h want %0h", bus_rr.fifo_level,
                         {5'd6, 5'd6});
    end
    tick();
    m_tready = 1'b1;
    wait_beats(12, 1'b0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL rr_timeout: got %0d beats want 12", cap_tid.size());
    end
    for (int k = 0; k < 12 && k < cap_tid.size(); k++) begin
      etid = (k / 2) % 2;
      n_tests++;
      if (cap_tid[k] != etid || cap_data[k] !== mk(etid, k / 4, k % 2) ||
          cap_last[k] !== ((k % 2) == 1) || cap_user[k] !== user_of(mk(etid, k / 4, k % 2))) begin
        n_fail++; $display("FAIL rr_beat%0d: tid %0d data %h last %b want %0d %h %b", k,
                           cap_tid[k], cap_data[k], cap_last[k], etid, mk(etid, k / 4, k % 2),
                           (k % 2) == 1);
      end
      if (k > 0) begin
        n_tests++;
        if (cap_cyc[k] - cap_cyc[k-1] != ((k % 2) == 1 ? 1 : 2)) begin
          n_fail++; $display("FAIL rr_gap%0d: got %0d want %0d", k, cap_cyc[k] - cap_cyc[k-1],
                             (k % 2) == 1 ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_fixed_priority();
    bit ok;
    int etid;
    int epkt;
    apply_reset();
    m_tready = 1'b0;
    load_two_ports();
    tick();
    m_tready = 1'b1;
    wait_beats(12, 1'b1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL fx_timeout: got %0d beats want 12", fx_tid.size());
    end
    for (int k = 0; k < 12 && k < fx_tid.size(); k++) begin
      etid = (k < 6) ? 0 : 1;
      epkt = (k % 6) / 2;
      n_tests++;
      if (fx_tid[k] != etid || fx_data[k] !== mk(etid, epkt, k % 2)) begin
        n_fail++; $display("FAIL fx_beat%0d: tid %0d data %h want %0d %h", k, fx_tid[k],
                           fx_data[k], etid, mk(etid, epkt, k % 2));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit acc;
    int n;
    apply_reset();
    m_tready = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 16; c++) begin
      set_beat(1, 32'hB000_0000 + 32'(n), 1'b0);
      @(negedge clk);
      acc = bus_rr.s_axis_tready[1];
      tick();
      if (acc) n++;
    end
    set_beat(1, 32'hB000_0010, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus_rr.s_axis_tready[1] !== 1'b0 || bus_rr.fifo_level[2*LW-1:LW] !== 5'd16) begin
        n_fail++; $display("FAIL bp_full%0d: tready %b level %0d want 0 16", c,
                           bus_rr.s_axis_tready[1], bus_rr.fifo_level[2*LW-1:LW]);
      end
      tick();
    end
    m_tready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_rr.s_axis_tready[1] !== 1'b0 || bus_rr.m_axis_tdata !== 32'hB000_0000) begin
      n_fail++; $display("FAIL bp_first_read: tready %b data %h want 0 b0000000",
                         bus_rr.s_axis_tready[1], bus_rr.m_axis_tdata);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_rr.s_axis_tready[1] !== 1'b1 || bus_rr.fifo_level[2*LW-1:LW] !== 5'd15) begin
      n_fail++; $display("FAIL bp_reopen: tready %b level %0d want 1 15",
                         bus_rr.s_axis_tready[1], bus_rr.fifo_level[2*LW-1:LW]);
    end
    tick();
    s_tvalid = '0;
    wait_beats(17, 1'b0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_timeout: got %0d beats want 17", cap_tid.size());
    end
    for (int k = 0; k < 17 && k < cap_tid.size(); k++) begin
      n_tests++;
      if (cap_tid[k] != 1 || cap_data[k] !== 32'hB000_0000 + 32'(k) ||
          cap_last[k] !== (k == 16)) begin
        n_fail++; $display("FAIL bp_beat%0d: tid %0d data %h last %b want 1 %h %b", k,
                           cap_tid[k], cap_data[k], cap_last[k], 32'hB000_0000 + 32'(k), k == 16);
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    logic [31:0] edata [5];
    int etid [5];
    edata = '{32'hD100_0000, 32'hD100_0001, 32'hD100_0002, 32'hD000_0000, 32'hD000_0001};
    etid  = '{1, 1, 1, 0, 0};
    apply_reset();
    m_tready = 1'b1;
    set_beat(1, 32'hD100_0000, 1'b0);
    tick();
    s_tvalid[1] = 1'b0;
    set_beat(0, 32'hD000_0000, 1'b0);
    tick();
    set_beat(0, 32'hD000_0001, 1'b1);
    tick();
    s_tvalid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) set_beat(1, 32'hD100_0001, 1'b0);
      @(negedge clk);
      n_tests++;
      if (bus_rr.m_axis_tvalid !== 1'b0 || bus_rr.m_axis_tid !== 1'b1) begin
        n_fail++; $display("FAIL underrun_gap%0d: tvalid %b tid %0d want 0 1", i,
                           bus_rr.m_axis_tvalid, bus_rr.m_axis_tid);
      end
      tick();
    end
    set_beat(1, 32'hD100_0002, 1'b1);
    @(negedge clk);
    n_tests++;
    if (bus_rr.m_axis_tvalid !== 1'b1 || bus_rr.m_axis_tid !== 1'b1) begin
      n_fail++; $display("FAIL underrun_resume: tvalid %b tid %0d want 1 1",
                         bus_rr.m_axis_tvalid, bus_rr.m_axis_tid);
    end
    tick();
    s_tvalid = '0;
    wait_beats(5, 1'b0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL underrun_timeout: got %0d beats want 5", cap_tid.size());
    end
    for (int k = 0; k < 5 && k < cap_tid.size(); k++) begin
      n_tests++;
      if (cap_tid[k] != etid[k] || cap_data[k] !== edata[k]) begin
        n_fail++; $display("FAIL underrun_beat%0d: tid %0d data %h want %0d %h", k,
                           cap_tid[k], cap_data[k], etid[k], edata[k]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    logic [31:0] edata [4];
    int etid [4];
    edata = '{32'hE000_0000, 32'hE000_0001, 32'hE200_0000, 32'hE200_0001};
    etid  = '{0, 0, 1, 1};
    apply_reset();
    m_tready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      set_beat(1, 32'hE100_0000 + 32'(b), 1'b0);
      tick();
    end
    s_tvalid = '0;
    @(negedge clk);
    n_tests++;
    if (bus_rr.m_axis_tvalid !== 1'b1 || bus_rr.m_axis_tid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_before: tvalid %b tid %0d want 1 1",
                         bus_rr.m_axis_tvalid, bus_rr.m_axis_tid);
    end
    tick();
    areset = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_rr.m_axis_tvalid !== 1'b0 || bus_rr.fifo_level !== '0 ||
        bus_rr.s_axis_tready !== 2'b00) begin
      n_fail++; $display("FAIL midrst_cleared: tvalid %b level %0h tready %b want 0 0 00",
                         bus_rr.m_axis_tvalid, bus_rr.fifo_level, bus_rr.s_axis_tready);
    end
    tick();
    areset = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_rr.s_axis_tready !== 2'b11) begin
      n_fail++; $display("FAIL midrst_ready: got %b want 11", bus_rr.s_axis_tready);
    end
    tick();
    clear_caps();
    m_tready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      set_beat(0, 32'hE000_0000 + 32'(b), b == 1);
      set_beat(1, 32'hE200_0000 + 32'(b), b == 1);
      tick();
    end
    s_tvalid = '0;
    wait_beats(4, 1'b0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL midrst_timeout: got %0d beats want 4", cap_tid.size());
    end
    for (int k = 0; k < 4 && k < cap_tid.size(); k++) begin
      n_tests++;
      if (cap_tid[k] != etid[k] || cap_data[k] !== edata[k]) begin
        n_fail++; $display("FAIL midrst_beat%0d: tid %0d data %h want %0d %h", k,
                           cap_tid[k], cap_data[k], etid[k], edata[k]);
      end
    end
    repeat (4) tick();
    n_tests++;
    if (cap_tid.size() != 4) begin
      n_fail++; $display("FAIL midrst_extra: got %0d beats want 4", cap_tid.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_underrun();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
